// File: rtl/psum_accum_pkg.sv
// Shared defaults, lane saturation limits and clear-sequencer state encoding
// for the partial-sum accumulator.
package psum_accum_pkg;

  localparam int DEF_COL     = 8;
  localparam int DEF_PSUM_BW = 16;
  localparam int DEF_DEPTH   = 16;

  localparam logic [DEF_PSUM_BW-1:0] LANE_MAX = {1'b0, {(DEF_PSUM_BW-1){1'b1}}};
  localparam logic [DEF_PSUM_BW-1:0] LANE_MIN = {1'b1, {(DEF_PSUM_BW-1){1'b0}}};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/psum_accum_sat.sv
// One accumulator lane: overwrite on first, otherwise signed add clamped to
// the lane range, with a flag when the clamp engaged.
module psum_sat_add
  import psum_accum_pkg::*;
#(
  parameter int PSUM_BW = DEF_PSUM_BW
) (
  input  logic [PSUM_BW-1:0] i_a,
  input  logic [PSUM_BW-1:0] i_b,
  input  logic               i_first,
  output logic [PSUM_BW-1:0] o_sum,
  output logic               o_sat
);

  localparam logic [PSUM_BW-1:0] SAT_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
  localparam logic [PSUM_BW-1:0] SAT_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};

  logic [PSUM_BW:0] w_ext;

  assign w_ext = {i_a[PSUM_BW-1], i_a} + {i_b[PSUM_BW-1], i_b};

  // The two top bits of the widened sum disagree exactly when it overflowed.
  always_comb begin
    o_sum = w_ext[PSUM_BW-1:0];
    o_sat = 1'b0;
    if (i_first) begin
      o_sum = i_b;
    end else if (w_ext[PSUM_BW] != w_ext[PSUM_BW-1]) begin
      o_sat = 1'b1;
      o_sum = w_ext[PSUM_BW] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/psum_accum.sv
// Partial-sum accumulator bank: 2-stage saturating accumulate, registered
// read port with optional ReLU and read-clear, plus a bank clear sequencer.
//   state    | meaning
//   ST_CLEAR | zeroing entry[r_clr_cnt] each cycle; ports not ready
//   ST_IDLE  | accepting accumulate and read requests
module psum_accum
  import psum_accum_pkg::*;
#(
  parameter int COL     = DEF_COL,
  parameter int PSUM_BW = DEF_PSUM_BW,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_clear_all,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic                   i_in_first,
  input  logic [AW-1:0]          i_in_addr,
  input  logic [COL*PSUM_BW-1:0] i_in_psum,
  input  logic                   i_rd_valid,
  output logic                   o_rd_ready,
  input  logic [AW-1:0]          i_rd_addr,
  input  logic                   i_rd_clear,
  input  logic                   i_relu_en,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [COL*PSUM_BW-1:0] o_out_psum,
  output logic                   o_sat_flag,
  output logic                   o_busy
);

  localparam int W = COL * PSUM_BW;

  state_e         r_state;
  state_e         w_state_nxt;
  logic [AW-1:0]  r_clr_cnt;
  logic [AW-1:0]  w_clr_cnt_nxt;

  logic [W-1:0]   r_bank [DEPTH];

  logic           r_s1_valid;
  logic           r_s1_first;
  logic [AW-1:0]  r_s1_addr;
  logic [W-1:0]   r_s1_psum;

  logic           r_out_valid;
  logic [W-1:0]   r_out_psum;
  logic           r_sat_flag;

  logic           w_in_ready;
  logic           w_rd_ready;
  logic           w_busy;
  logic           w_in_fire;
  logic           w_rd_fire;
  logic           w_s1_in_range;
  logic           w_rd_in_range;
  logic           w_fwd;
  logic           w_s1_write;
  logic [W-1:0]   w_s1_entry;
  logic [W-1:0]   w_wr_data;
  logic [W-1:0]   w_rd_raw;
  logic [W-1:0]   w_rd_data;
  logic [COL-1:0] w_lane_sat;

  // Address guards collapse to constants when the bank fills the address space.
  if (DEPTH == (1 << AW)) begin : g_full
    assign w_s1_in_range = 1'b1;
    assign w_rd_in_range = 1'b1;
  end else begin : g_part
    assign w_s1_in_range = (int'(r_s1_addr) < DEPTH);
    assign w_rd_in_range = (int'(i_rd_addr) < DEPTH);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_in_ready    = 1'b0;
    w_busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = !i_clear_all;
        if (i_clear_all) begin
          w_state_nxt   = ST_CLEAR;
          w_clr_cnt_nxt = '0;
        end
      end
      ST_CLEAR: begin
        w_busy = 1'b1;
        if (i_clear_all) begin
          w_clr_cnt_nxt = '0;
        end else if (r_clr_cnt == AW'(DEPTH - 1)) begin
          w_state_nxt   = ST_IDLE;
          w_clr_cnt_nxt = '0;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  assign w_rd_ready = w_in_ready && (!r_out_valid || i_out_ready);
  assign w_in_fire  = i_in_valid && w_in_ready;
  assign w_rd_fire  = i_rd_valid && w_rd_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_in_fire;
    end
    if (w_in_fire) begin
      r_s1_addr  <= i_in_addr;
      r_s1_first <= i_in_first;
      r_s1_psum  <= i_in_psum;
    end
  end

  // The bank is read live at write time, so a back-to-back op on the same
  // entry already sees its predecessor's result without a bubble.
  assign w_s1_entry = w_s1_in_range ? r_bank[r_s1_addr] : '0;
  assign w_s1_write = r_s1_valid && w_s1_in_range;

  for (genvar k = 0; k < COL; k++) begin : g_lane
    psum_sat_add #(.PSUM_BW(PSUM_BW)) u_add (
      .i_a     (w_s1_entry[k*PSUM_BW +: PSUM_BW]),
      .i_b     (r_s1_psum[k*PSUM_BW +: PSUM_BW]),
      .i_first (r_s1_first),
      .o_sum   (w_wr_data[k*PSUM_BW +: PSUM_BW]),
      .o_sat   (w_lane_sat[k])
    );
  end

  // A read on the same edge as a committing write returns the post-write sum.
  assign w_fwd = r_s1_valid && (r_s1_addr == i_rd_addr);

  always_comb begin
    w_rd_raw = '0;
    if (w_rd_in_range) begin
      w_rd_raw = w_fwd ? w_wr_data : r_bank[i_rd_addr];
    end
    w_rd_data = w_rd_raw;
    if (i_relu_en) begin
      for (int k = 0; k < COL; k++) begin
        if (w_rd_raw[k*PSUM_BW + PSUM_BW - 1]) begin
          w_rd_data[k*PSUM_BW +: PSUM_BW] = '0;
        end
      end
    end
  end

  // Read-clear yields to a write landing on the same entry.
  always_ff @(posedge i_clk) begin
    if (w_s1_write) begin
      r_bank[r_s1_addr] <= w_wr_data;
    end
    if (w_rd_fire && i_rd_clear && w_rd_in_range && !w_fwd) begin
      r_bank[i_rd_addr] <= '0;
    end
    if (r_state == ST_CLEAR) begin
      r_bank[r_clr_cnt] <= '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_out_valid <= 1'b0;
      r_out_psum  <= '0;
    end else if (w_rd_fire) begin
      r_out_valid <= 1'b1;
      r_out_psum  <= w_rd_data;
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // A clear request wins over a saturation from the op draining on that edge,
  // since that op's result is about to be zeroed anyway.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sat_flag <= 1'b0;
    end else if (i_clear_all) begin
      r_sat_flag <= 1'b0;
    end else if (w_s1_write && (|w_lane_sat)) begin
      r_sat_flag <= 1'b1;
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_rd_ready  = w_rd_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_psum  = r_out_psum;
  assign o_sat_flag  = r_sat_flag;
  assign o_busy      = w_busy;

endmodule

// File: doc/psum_accum.md
Name: psum_accum

Overview:
Downstream of the mac array / output FIFO. Accepts one row of col signed partial sums per transaction and accumulates them into a small register-file bank indexed by output position, using a per-lane saturating add. Drains accumulated rows through a valid/ready read port with optional ReLU, for writeback to SRAM. Includes a clear sequencer that zeroes the bank after reset or on command.

Parameters:
col, 8, number of lanes (array columns) per row
psum_bw, 16, signed partial-sum width per lane
depth, 16, number of accumulator entries (output positions)
aw, 4, address width; must equal clog2(depth)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
clear_all  input  1  one-cycle pulse; starts a bank clear
in_valid  input  1  accumulate request valid
in_ready  output  1  accumulate request accepted when in_valid & in_ready
in_first  input  1  1: overwrite entry with in_psum; 0: add to entry
in_addr  input  aw  target entry
in_psum  input  col*psum_bw  lane k at bits [k*psum_bw +: psum_bw], signed
rd_valid  input  1  read request valid
rd_ready  output  1  read request accepted when rd_valid & rd_ready
rd_addr  input  aw  entry to read
rd_clear  input  1  zero the entry after reading it
relu_en  input  1  apply ReLU to read data; sampled with the read request
out_valid  output  1  out_psum holds valid data
out_ready  input  1  consumer accepts out_psum
out_psum  output  col*psum_bw  read data, same lane packing
sat_flag  output  1  sticky; set when any lane saturated
busy  output  1  clear sequencer active

Behaviour:
- Reset: state CLEAR, clear counter 0, S1 valid 0, out_valid 0, out_psum 0, sat_flag 0, busy 1. Bank contents are not reset directly; the CLEAR sequence zeroes them.
- FSM:
  - CLEAR: zero entry[cnt] per cycle; cnt wraps from depth-1 to 0; then go to IDLE. Lasts exactly depth cycles.
  - IDLE: go to CLEAR on clear_all.
  - clear_all while in CLEAR restarts cnt at 0.
  - Entering CLEAR from clear_all clears sat_flag.
- in_ready and rd_ready are 1 only in IDLE with clear_all low.
- The S1 in-flight op drains normally when clear_all arrives. Its write lands before the CLEAR pass reaches that entry, so it is zeroed.
- Accumulate pipeline, 2 stages, fully pipelined (1 accepted op per cycle):
  - S1 registers addr, first, psum.
  - S2 (next edge) writes entry = first ? psum : sat(entry + psum), per lane.
  - Entry updated 2 edges after acceptance.
- Back-to-back same-address ops: the second op sees the first op's result. Implement with a forward from the S2 write data into the S2 read when addresses match. No bubble allowed.
- Saturating add, per lane, signed psum_bw:
  - Compute in psum_bw+1 bits.
  - If result > 2^(psum_bw-1)-1, clamp to max; if < -2^(psum_bw-1), clamp to min.
  - Any clamp sets sat_flag on the write edge.
- Read path, registered output:
  - Accepted only when !out_valid or out_ready (rd_ready includes this term).
  - On accept, out_psum = entry (per lane, 0 if negative and relu_en) and out_valid = 1 on the next edge.
  - out_valid drops on out_ready when no new read is accepted.
  - A held out_psum is stable while out_valid & !out_ready.
- Read vs. pending write: a read of an address with a write committing on the same edge returns the post-write value (forward from S2). A read of an address held in S1 returns the value without S1's contribution.
- rd_clear zeroes the entry on the accept edge. If an S2 write to the same entry commits on that edge, the write wins and the clear is dropped. The read data is the forwarded sum.
- Out-of-range addresses are impossible when depth = 2^aw. Otherwise, writes to them are ignored and reads of them return 0.

Decomposition:
- Shared package:
  - Parameter defaults COL, PSUM_BW, DEPTH.
  - Lane max/min constants.
  - FSM state encoding (ST_IDLE, ST_CLEAR).
- One sub-module, psum_sat_add: a combinational per-lane saturating adder (a, b, first) → (sum, sat). Instantiated col times by a generate loop.

Test Plan:
- Reset, then wait: busy=1 for 16 cycles, then in_ready=1 and rd_ready=1; reading every address returns all zeros.
- Write addr 3, first=1, all lanes 5; then two back-to-back adds to addr 3 with lane values 7 and -20 → read addr 3 returns -8 per lane, sat_flag=0.
- Write lane0 = 32767 (first=1), then add 1 → read returns 32767 and sat_flag=1. Then write lane0 = -32768 and add -1 → read returns -32768.
- Store -8 in addr 3, read with relu_en=1 and out_ready held low for 3 cycles → out_psum stays 0 and out_valid stays 1; a second rd_valid is not accepted until out_ready=1.
- Read addr 5 with rd_clear on the same cycle its S2 write of 9 commits → out_psum=9 and the entry still holds 9. Then read with rd_clear and no write → the following read returns 0.
- After accumulating several entries, pulse clear_all → in_ready=0 for 16 cycles, then all entries read 0 and sat_flag=0. A second pulse at cycle 5 of the clear extends busy to 21 cycles total.
